// File: rtl/matrix_store_if.sv
// matrix_store_if: vector-in handshake and byte-wide memory write bus for matrix_store_serializer
interface matrix_store_if #(
  parameter int WIDTH_V    = 128,
  parameter int BITS_INDEX = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH_V-1:0]    in_vector;
  logic [ADDR_WIDTH-1:0] in_base_addr;
  logic                  mem_we;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BITS_INDEX-1:0] mem_wdata;
  modport master (
    output in_valid, in_vector, in_base_addr, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  in_valid, in_vector, in_base_addr, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/matrix_store_serializer.sv
// matrix_store_serializer: writes a packed 4x4 byte matrix as 16 memory beats from a latched base; MATRIX_STORE_TRANSPOSE_EN adds column-major storage
module matrix_store_serializer #(
  parameter int WIDTH_V     = 128,
  parameter int BITS_INDEX  = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int MATRIX_SIZE = 4
) (
  input  logic           clk,
  input  logic           rst,
`ifdef MATRIX_STORE_TRANSPOSE_EN
  input  logic           transpose,
`endif
  matrix_store_if.slave  io,
  output logic           busy,
  output logic           done
);
  localparam int N  = MATRIX_SIZE * MATRIX_SIZE;
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [WIDTH_V-1:0]    vec_q, vec_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [IW-1:0]         sel;
  logic [BITS_INDEX-1:0] elems [N];
  for (genvar g = 0; g < N; g++) begin : g_elem
    assign elems[g] = vec_q[WIDTH_V-1-g*BITS_INDEX -: BITS_INDEX];
  end
`ifdef MATRIX_STORE_TRANSPOSE_EN
  localparam int LM = $clog2(MATRIX_SIZE);
  logic tr_q, tr_d;
  assign sel = tr_q ? {idx_q[LM-1:0], idx_q[IW-1:LM]} : idx_q;
`else
  assign sel = idx_q;
`endif
  assign io.in_ready  = state_q == IDLE;
  assign io.mem_we    = state_q == SEND;
  assign io.mem_addr  = state_q == SEND ? base_q + ADDR_WIDTH'(idx_q) : '0;
  assign io.mem_wdata = state_q == SEND ? elems[sel] : '0;
  assign busy         = state_q != IDLE;
  assign done         = state_q == DONE;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    base_d  = base_q;
`ifdef MATRIX_STORE_TRANSPOSE_EN
    tr_d    = tr_q;
`endif
    if (state_q == IDLE && io.in_valid) begin
      state_d = SEND;
      idx_d   = '0;
      vec_d   = io.in_vector;
      base_d  = io.in_base_addr;
`ifdef MATRIX_STORE_TRANSPOSE_EN
      tr_d    = transpose;
`endif
    end else if (state_q == SEND && io.mem_ready) begin
      state_d = idx_q == IW'(N-1) ? DONE : SEND;
      idx_d   = idx_q + IW'(1);
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      base_q  <= '0;
`ifdef MATRIX_STORE_TRANSPOSE_EN
      tr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      base_q  <= base_d;
`ifdef MATRIX_STORE_TRANSPOSE_EN
      tr_q    <= tr_d;
`endif
    end
  end
endmodule

// File: tb/tb_matrix_store_serializer.sv
// tb_matrix_store_serializer: directed self-checking bench for matrix_store_serializer
module tb_matrix_store_serializer;
  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic done;
`ifdef MATRIX_STORE_TRANSPOSE_EN
  logic transpose = 1'b0;
`endif
  int errors = 0;
  int checks = 0;
  logic [7:0] elem  [16];
  logic [7:0] exp_w [16];
  always #5 clk = ~clk;
  matrix_store_if #(.WIDTH_V(128), .BITS_INDEX(8), .ADDR_WIDTH(16)) bus ();
  matrix_store_serializer #(.WIDTH_V(128), .BITS_INDEX(8), .ADDR_WIDTH(16), .MATRIX_SIZE(4)) dut (
    .clk(clk),
    .rst(rst),
`ifdef MATRIX_STORE_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .io(bus),
    .busy(busy),
    .done(done)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] pack();
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[127-8*k -: 8] = elem[k];
    return v;
  endfunction
  task automatic offer(input logic [15:0] base);
    bus.in_vector    = pack();
    bus.in_base_addr = base;
    bus.in_valid     = 1'b1;
    bus.mem_ready    = 1'b1;
    check("accept_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid     = 1'b0;
    bus.in_vector    = '1;
    bus.in_base_addr = 16'hDEAD;
  endtask
  task automatic transfer(input string tag, input logic [15:0] base, input int sa, input int sb,
                          input int exp_done, input bit poke);
    int n = 0;
    int sc = 0;
    int cyc = 1;
    bit fin = 1'b0;
    logic [15:0] ea;
    while (!fin && cyc < 64) begin
      if (poke && cyc == 3) begin
        bus.in_valid     = 1'b1;
        bus.in_vector    = {16{8'hA5}};
        bus.in_base_addr = 16'h4000;
      end
      if (done) begin
        fin = 1'b1;
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done));
        check({tag, "_beats"}, 32'(n), 16);
        check({tag, "_done_we"}, 32'(bus.mem_we), 0);
        check({tag, "_done_in_ready"}, 32'(bus.in_ready), 0);
        bus.in_valid = 1'b0;
      end else if (n > 15) begin
        fin = 1'b1;
        check({tag, "_extra_beat"}, 32'(bus.mem_we), 0);
      end else begin
        ea = base + 16'(n);
        check({tag, "_we"}, 32'(bus.mem_we), 1);
        check({tag, "_busy"}, 32'(busy), 1);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        check({tag, "_addr"}, 32'(bus.mem_addr), 32'(ea));
        check({tag, "_data"}, 32'(bus.mem_wdata), 32'(exp_w[n]));
        bus.mem_ready = !((n == sa || n == sb) && sc < 2);
        if (!bus.mem_ready) sc++;
        else begin
          n++;
          sc = 0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!fin) check({tag, "_timeout"}, 0, 1);
    bus.mem_ready = 1'b1;
    check({tag, "_after_in_ready"}, 32'(bus.in_ready), 1);
    check({tag, "_after_busy"}, 32'(busy), 0);
    check({tag, "_after_done"}, 32'(done), 0);
    check({tag, "_after_we"}, 32'(bus.mem_we), 0);
  endtask
  initial begin
    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_vector    = '0;
    bus.in_base_addr = '0;
    bus.mem_ready    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_we", 32'(bus.mem_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_wdata", 32'(bus.mem_wdata), 0);
    rst = 1'b0;
    @(negedge clk);
    elem  = '{20, 16, 20, 16, 21, 19, 21, 19, 24, 12, 24, 12, 24, 16, 24, 16};
    exp_w = elem;
    offer(16'h0100);
    transfer("single", 16'h0100, -1, -1, 17, 1'b0);
    for (int k = 0; k < 16; k++) elem[k] = 8'd24;
    exp_w = elem;
    offer(16'h0200);
    transfer("stall", 16'h0200, 3, 10, 21, 1'b0);
    for (int k = 0; k < 16; k++) elem[k] = 8'(3 * k + 1);
    exp_w = elem;
    offer(16'hFFF8);
    transfer("wrap", 16'hFFF8, -1, -1, 17, 1'b0);
    for (int k = 0; k < 16; k++) elem[k] = 8'(8'h30 + k);
    exp_w = elem;
    offer(16'h0800);
    transfer("ignore", 16'h0800, -1, -1, 17, 1'b1);
    for (int k = 0; k < 16; k++) elem[k] = 8'(8'h70 + k);
    exp_w = elem;
    offer(16'h1000);
    for (int k = 0; k < 6; k++) begin
      check("abort_addr", 32'(bus.mem_addr), 32'(16'h1000 + 16'(k)));
      check("abort_data", 32'(bus.mem_wdata), 32'(exp_w[k]));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_we", 32'(bus.mem_we), 0);
    check("abort_done", 32'(done), 0);
    check("abort_in_ready", 32'(bus.in_ready), 1);
    check("abort_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_done", 32'(done), 0);
    check("abort_idle_we", 32'(bus.mem_we), 0);
    for (int k = 0; k < 16; k++) elem[k] = 8'(8'hC0 + 2 * k);
    exp_w = elem;
    offer(16'h2000);
    transfer("fresh", 16'h2000, -1, -1, 17, 1'b0);
`ifdef MATRIX_STORE_TRANSPOSE_EN
    for (int k = 0; k < 16; k++) elem[k] = 8'(k);
    exp_w = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    transpose = 1'b1;
    offer(16'h3000);
    transpose = 1'b0;
    transfer("transpose", 16'h3000, -1, -1, 17, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
